shift_register: RTL and testbench
=================================

// Module: shift_register
// PURPOSE
//   WIDTH-bit shift register for the SPI-style peripheral datapath.
//   Serial input enters at the MSB and leaves at the LSB (LSB-first out). Parallel load and parallel readback are provided.
//   Runs entirely on the system clock.
//   Shifting and loading are qualified by a one-cycle strobe, peripheral_clk_edge, from the upstream serial-clock edge detector.
// PARAMETERS
//   WIDTH  8  register width in bits (>= 2)
// PORTS
//   clk                  in   1      system clock; all state updates on posedge
//   reset                in   1      synchronous, active-high reset
//   peripheral_clk_edge  in   1      one-clk strobe; qualifies shift or load
//   parallel_load        in   1      load parallel_data_in on the next strobe
//   parallel_data_in     in   WIDTH  word to load
//   serial_data_in       in   1      bit shifted into the MSB
//   parallel_data_out    out  WIDTH  current register contents
//   serial_data_out      out  1      current register LSB
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset: on posedge clk with reset=1, the register becomes 0, so both outputs are 0. Reset overrides every other input.
//   - Posedge clk, reset=0, peripheral_clk_edge=1, parallel_load=1: mem <= parallel_data_in. Load has priority over shift.
//   - Posedge clk, reset=0, peripheral_clk_edge=1, parallel_load=0: mem <= {serial_data_in, mem[WIDTH-1:1]}.
//   - peripheral_clk_edge=0: mem holds. parallel_load is ignored without the strobe.
//   - Outputs are combinational from the register (parallel_data_out=mem, serial_data_out=mem[0]). No extra output latency: new value is visible right after the updating edge.
//   - A strobe held high for N cycles performs N operations. There is no internal edge detection.
//   - No X propagation from reset; all inputs are sampled only at posedge clk.
// CONFIGURATION
//   SHIFTREG_BIT_COUNT_EN defined:
//     - Adds outputs bit_count [$clog2(WIDTH+1)-1:0] and word_done (1 bit).
//     - bit_count resets to 0, is cleared by a strobed load, and increments on each strobed shift.
//     - On the shift that brings bit_count to WIDTH, bit_count wraps to 0 and word_done pulses high for exactly one clk.
//     - word_done is 0 at reset and after a load.
//   SHIFTREG_BIT_COUNT_EN undefined: these ports and the counter logic do not exist. Core behaviour is identical either way.
// STRUCTURE
//   - Package shift_register_pkg holds SHIFTREG_DEFAULT_WIDTH=8, RESET_VALUE='0, and typedef enum {OP_HOLD, OP_SHIFT, OP_LOAD} sr_op_t. The enum is used for op decode.
//   - Optional sub-module shift_register_bit_counter (WIDTH parameter) implements the bit counter. It is instantiated only under SHIFTREG_BIT_COUNT_EN.
//   - The core register and op decode stay in shift_register.
// TESTING (WIDTH=8)
//   1. reset=1 for 1 clk with random inputs -> parallel_data_out=8'h00, serial_data_out=0.
//   2. parallel_load=1, parallel_data_in=8'hA5, strobe 1 clk -> out=8'hA5, serial_data_out=1. Load with strobe=0 -> register unchanged.
//   3. From 0, shift serial bits 1,0,1,0,1,0,1,0 (one strobe each) -> out=8'h55. From 8'hA5, one strobed shift of 1 -> 8'hD2.
//   4. Strobe with parallel_load=1 and serial_data_in=1, data_in=8'h3C -> 8'h3C (load wins). Strobe low 10 clks -> value held.
//   5. reset asserted mid-sequence after 4 shifts -> 8'h00 next clk. Later strobes resume shifting from 0.
//   6. With SHIFTREG_BIT_COUNT_EN: 8 strobed shifts -> bit_count 1..7 then 0, word_done=1 only on the 8th shift. A load clears bit_count.

Source files
------------

// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared constants and op encoding for the shift register
package shift_register_pkg;

   localparam int SHIFTREG_DEFAULT_WIDTH = 8;
   localparam logic RESET_VALUE = 1'b0;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_SHIFT,
      OP_LOAD
   } sr_op_t;

endpackage

// File: rtl/shift_register_if.sv
// rtl/shift_register_if.sv - strobe/data bundle of the shift register
// Optional bit_count/word_done members exist only with SHIFTREG_BIT_COUNT_EN.
interface shift_register_if
   import shift_register_pkg::*;
#(
   parameter int WIDTH = SHIFTREG_DEFAULT_WIDTH
);

   logic             peripheral_clk_edge;
   logic             parallel_load;
   logic [WIDTH-1:0] parallel_data_in;
   logic             serial_data_in;
   logic [WIDTH-1:0] parallel_data_out;
   logic             serial_data_out;
`ifdef SHIFTREG_BIT_COUNT_EN
   logic [$clog2(WIDTH+1)-1:0] bit_count;
   logic                       word_done;
`endif

   modport master (
      output peripheral_clk_edge, parallel_load, parallel_data_in, serial_data_in,
`ifdef SHIFTREG_BIT_COUNT_EN
      input  bit_count, word_done,
`endif
      input  parallel_data_out, serial_data_out
   );

   modport slave (
      input  peripheral_clk_edge, parallel_load, parallel_data_in, serial_data_in,
`ifdef SHIFTREG_BIT_COUNT_EN
      output bit_count, word_done,
`endif
      output parallel_data_out, serial_data_out
   );

endinterface

// File: rtl/shift_register_bit_counter.sv
// rtl/shift_register_bit_counter.sv - counts strobed shifts, pulses wordDone on each full word
// Instantiated only when SHIFTREG_BIT_COUNT_EN is defined.
module shift_register_bit_counter
   import shift_register_pkg::*;
#(
   parameter int WIDTH = SHIFTREG_DEFAULT_WIDTH,
   localparam int CW   = $clog2(WIDTH+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  sr_op_t        op,
   output logic [CW-1:0] bitCount,
   output logic          wordDone
);

   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         bitCount <= '0;
         wordDone <= 1'b0;
      end else begin
         wordDone <= 1'b0;
         unique case (op)
            OP_LOAD: bitCount <= '0;
            OP_SHIFT: begin
               // Reaching WIDTH wraps straight to zero; WIDTH itself is never held.
               if (bitCount == LastBit) begin
                  bitCount <= '0;
                  wordDone <= 1'b1;
               end else begin
                  bitCount <= bitCount + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - strobe-qualified LSB-first shift register with parallel load
// Define SHIFTREG_BIT_COUNT_EN to add the bit_count/word_done word tracker.
module shift_register
   import shift_register_pkg::*;
#(
   parameter int WIDTH = SHIFTREG_DEFAULT_WIDTH
) (
   input logic               clk,
   input logic               reset,
   shift_register_if.slave   bus
);

   logic [WIDTH-1:0] mem;
   sr_op_t           op;

   // Load outranks shift; nothing happens without the edge strobe.
   always_comb begin
      op = OP_HOLD;
      if (bus.peripheral_clk_edge) begin
         op = bus.parallel_load ? OP_LOAD : OP_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= {WIDTH{RESET_VALUE}};
      end else begin
         unique case (op)
            OP_LOAD:  mem <= bus.parallel_data_in;
            OP_SHIFT: mem <= {bus.serial_data_in, mem[WIDTH-1:1]};
            default:  mem <= mem;
         endcase
      end
   end

   assign bus.parallel_data_out = mem;
   assign bus.serial_data_out   = mem[0];

`ifdef SHIFTREG_BIT_COUNT_EN
   shift_register_bit_counter #(
      .WIDTH    (WIDTH)
   ) bitCounter (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .bitCount (bus.bit_count),
      .wordDone (bus.word_done)
   );
`endif

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - directed-vector bench for shift_register (WIDTH=8)
// Bit-counter vectors run only when SHIFTREG_BIT_COUNT_EN is defined.
module tb_shift_register;

   logic clk = 1'b0;
   logic reset;
   int   vectorCount = 0;
   int   missCount   = 0;

   always #5 clk = ~clk;

   shift_register_if #(.WIDTH(8)) bus ();

   shift_register #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectorCount++;
      if (got !== want) begin
         missCount++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic edgeIn, input logic loadIn, input logic [7:0] dataIn, input logic serialIn);
      bus.peripheral_clk_edge = edgeIn;
      bus.parallel_load       = loadIn;
      bus.parallel_data_in    = dataIn;
      bus.serial_data_in      = serialIn;
   endtask

   initial begin
      logic [7:0] pattern;
      drive(1'b1, 1'b1, 8'($urandom), 1'($urandom));
      reset = 1'b1;
      tick();
      checkValue("reset_pout", 32'(bus.parallel_data_out), 32'h00);
      checkValue("reset_sout", 32'(bus.serial_data_out), 32'h0);
`ifdef SHIFTREG_BIT_COUNT_EN
      checkValue("reset_count", 32'(bus.bit_count), 32'h0);
      checkValue("reset_done", 32'(bus.word_done), 32'h0);
`endif
      reset = 1'b0;

      drive(1'b1, 1'b1, 8'hA5, 1'b0);
      tick();
      checkValue("load_a5", 32'(bus.parallel_data_out), 32'hA5);
      checkValue("load_a5_sout", 32'(bus.serial_data_out), 32'h1);
      drive(1'b0, 1'b1, 8'hFF, 1'b0);
      tick();
      checkValue("load_no_strobe", 32'(bus.parallel_data_out), 32'hA5);

      drive(1'b1, 1'b0, 8'h00, 1'b1);
      tick();
      checkValue("shift_a5_1", 32'(bus.parallel_data_out), 32'hD2);
      checkValue("shift_a5_1_sout", 32'(bus.serial_data_out), 32'h0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      pattern = 8'b0101_0101;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'h00, pattern[i]);
         tick();
      end
      checkValue("shift_1010", 32'(bus.parallel_data_out), 32'h55);
      checkValue("shift_1010_sout", 32'(bus.serial_data_out), 32'h1);

      drive(1'b1, 1'b1, 8'h3C, 1'b1);
      tick();
      checkValue("load_wins", 32'(bus.parallel_data_out), 32'h3C);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
         tick();
         checkValue($sformatf("hold_%0d", i), 32'(bus.parallel_data_out), 32'h3C);
      end

      drive(1'b1, 1'b0, 8'h00, 1'b1);
      tick();
      checkValue("shift4_1", 32'(bus.parallel_data_out), 32'h9E);
      tick();
      tick();
      tick();
      checkValue("shift4_4", 32'(bus.parallel_data_out), 32'hF3);
      reset = 1'b1;
      tick();
      checkValue("mid_reset", 32'(bus.parallel_data_out), 32'h00);
      reset = 1'b0;
      tick();
      checkValue("resume_1", 32'(bus.parallel_data_out), 32'h80);
      tick();
      checkValue("resume_2", 32'(bus.parallel_data_out), 32'hC0);

`ifdef SHIFTREG_BIT_COUNT_EN
      drive(1'b1, 1'b1, 8'h00, 1'b0);
      tick();
      checkValue("cnt_load_clear", 32'(bus.bit_count), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 8'h00, 1'b1);
         tick();
         checkValue($sformatf("cnt_%0d", k), 32'(bus.bit_count), 32'(k % 8));
         checkValue($sformatf("done_%0d", k), 32'(bus.word_done), 32'(k == 8));
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      checkValue("done_drop", 32'(bus.word_done), 32'h0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      tick();
      checkValue("cnt_3", 32'(bus.bit_count), 32'h3);
      drive(1'b1, 1'b1, 8'h11, 1'b0);
      tick();
      checkValue("cnt_after_load", 32'(bus.bit_count), 32'h0);
      checkValue("done_after_load", 32'(bus.word_done), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
